// File: rtl/uart_rx_cfg_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_cfg_if
// Brief    : Ready/valid output bundle of the configurable UART receiver.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 break_det;

    modport master (
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        output break_det,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        input  break_det,
        output rx_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_cfg
// Brief    : Parametrised UART receiver with false-start rejection, error
//            detection and a ready/valid holding register.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 8,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_serial,
    uart_rx_cfg_if.master rx_if,
    output logic          overrun,
    output logic          busy
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [c_CNT_W-1:0] c_HALF      = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL      = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_DATA = c_IDX_W'(DATA_BITS - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_STOP = c_IDX_W'(STOP_BITS - 1);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_START     = 3'd1;
    localparam logic [2:0] c_ST_DATA      = 3'd2;
    localparam logic [2:0] c_ST_PARITY    = 3'd3;
    localparam logic [2:0] c_ST_STOP      = 3'd4;
    localparam logic [2:0] c_ST_WAIT_HIGH = 3'd5;

    logic                 r_sync1;
    logic                 r_sync2;
    logic [2:0]           r_state;
    logic [c_CNT_W-1:0]   r_clk_cnt;
    logic [c_IDX_W-1:0]   r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 r_stop_any_low;
    logic                 r_stop_all_low;
    logic                 r_done;

    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_break_det;
    logic                 r_overrun;

    logic w_rx_s;
    logic w_tick;
    logic w_par_x;
    logic w_par_err;
    logic w_break;

    assign w_rx_s    = r_sync2;
    assign w_tick    = (r_clk_cnt == c_FULL);
    assign w_par_x   = (^r_shift) ^ r_par_bit;
    assign w_par_err = (PARITY_MODE == 1) ? w_par_x :
                       (PARITY_MODE == 2) ? ~w_par_x : 1'b0;
    assign w_break   = (r_shift == '0) && ((PARITY_MODE == 0) || !r_par_bit) && r_stop_all_low;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_serial;
            r_sync2 <= r_sync1;
        end
    end

    // Frame FSM; r_done pulses the cycle after the final stop-bit sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= c_ST_IDLE;
            r_clk_cnt      <= '0;
            r_bit_idx      <= '0;
            r_shift        <= '0;
            r_par_bit      <= 1'b0;
            r_stop_any_low <= 1'b0;
            r_stop_all_low <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                    if (!w_rx_s) begin
                        r_state        <= c_ST_START;
                        r_stop_any_low <= 1'b0;
                        r_stop_all_low <= 1'b1;
                    end
                end
                c_ST_START: begin
                    if (r_clk_cnt == c_HALF) begin
                        r_clk_cnt <= '0;
                        r_state   <= w_rx_s ? c_ST_IDLE : c_ST_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                c_ST_DATA: begin
                    if (w_tick) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        if (r_bit_idx == c_LAST_DATA) begin
                            r_bit_idx <= '0;
                            r_state   <= (PARITY_MODE != 0) ? c_ST_PARITY : c_ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                c_ST_PARITY: begin
                    if (w_tick) begin
                        r_clk_cnt <= '0;
                        r_par_bit <= w_rx_s;
                        r_state   <= c_ST_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                c_ST_STOP: begin
                    if (w_tick) begin
                        r_clk_cnt <= '0;
                        if (w_rx_s) begin
                            r_stop_all_low <= 1'b0;
                        end else begin
                            r_stop_any_low <= 1'b1;
                        end
                        if (r_bit_idx == c_LAST_STOP) begin
                            r_bit_idx <= '0;
                            r_done    <= 1'b1;
                            // A low final stop bit means the line may be in break; wait it out.
                            r_state   <= w_rx_s ? c_ST_IDLE : c_ST_WAIT_HIGH;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                c_ST_WAIT_HIGH: begin
                    if (w_rx_s) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Holding register: commit has priority; a blocked commit only flags overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_break_det  <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (r_done && (!r_rx_valid || rx_if.rx_ready)) begin
            r_rx_data    <= r_shift;
            r_rx_valid   <= 1'b1;
            r_parity_err <= w_par_err;
            r_frame_err  <= r_stop_any_low;
            r_break_det  <= w_break;
            r_overrun    <= 1'b0;
        end else if (r_done) begin
            r_overrun <= 1'b1;
        end else if (r_rx_valid && rx_if.rx_ready) begin
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_break_det  <= 1'b0;
            r_overrun    <= 1'b0;
        end
    end

    assign rx_if.rx_data    = r_rx_data;
    assign rx_if.rx_valid   = r_rx_valid;
    assign rx_if.parity_err = r_parity_err;
    assign rx_if.frame_err  = r_frame_err;
    assign rx_if.break_det  = r_break_det;
    assign overrun          = r_overrun;
    assign busy             = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_cfg
// Brief    : Scoreboard bench for uart_rx_cfg: an 8N1 instance and an
//            8E2 instance, directed scenarios plus random frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cfg;

    localparam int CPB0 = 8;
    localparam int PM0  = 0;
    localparam int SB0  = 1;
    localparam int CPB1 = 5;
    localparam int PM1  = 1;
    localparam int SB1  = 2;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ser0  = 1'b1;
    logic ser1  = 1'b1;
    logic rdy0  = 1'b1;
    logic rdy1  = 1'b1;
    logic ovr0, ovr1, busy0, busy1;

    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   stop_cyc = 0;
    bit   lat_en   = 1'b0;
    logic pv0      = 1'b0;
    exp_t q0[$];
    exp_t q1[$];

    always #50 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_cfg_if #(.DATA_BITS(8)) if0 ();
    uart_rx_cfg_if #(.DATA_BITS(8)) if1 ();
    assign if0.rx_ready = rdy0;
    assign if1.rx_ready = rdy1;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB0), .DATA_BITS(8), .PARITY_MODE(PM0), .STOP_BITS(SB0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .rx_serial(ser0), .rx_if(if0), .overrun(ovr0), .busy(busy0)
    );
    uart_rx_cfg #(.CLKS_PER_BIT(CPB1), .DATA_BITS(8), .PARITY_MODE(PM1), .STOP_BITS(SB1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .rx_serial(ser1), .rx_if(if1), .overrun(ovr1), .busy(busy1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic good_par(input int k, input logic [7:0] d);
        int pm;
        pm = (k == 0) ? PM0 : PM1;
        return (pm == 2) ? ~(^d) : (^d);
    endfunction

    // Expected outcome of one frame from the line-level rules alone.
    function automatic exp_t model(input int k, input logic [7:0] d, input logic par, input logic [1:0] stops);
        int   pm, sb, ones;
        exp_t e;
        pm     = (k == 0) ? PM0 : PM1;
        sb     = (k == 0) ? SB0 : SB1;
        ones   = $countones(d) + int'(par);
        e.data = d;
        e.perr = (pm != 0) && ((ones % 2) != ((pm == 2) ? 1 : 0));
        e.ferr = (stops[0] == 1'b0) || ((sb == 2) && (stops[1] == 1'b0));
        e.brk  = (d == 8'h00) && ((pm == 0) || (par == 1'b0)) &&
                 (stops[0] == 1'b0) && ((sb == 1) || (stops[1] == 1'b0));
        return e;
    endfunction

    task automatic drive(input int k, input logic b);
        if (k == 0) ser0 = b;
        else        ser1 = b;
    endtask

    task automatic send_frame(input int k, input logic [7:0] d, input logic par,
                              input logic [1:0] stops, input bit expect_out);
        int cpb, pm, sb;
        cpb = (k == 0) ? CPB0 : CPB1;
        pm  = (k == 0) ? PM0  : PM1;
        sb  = (k == 0) ? SB0  : SB1;
        if (expect_out) begin
            if (k == 0) q0.push_back(model(k, d, par, stops));
            else        q1.push_back(model(k, d, par, stops));
        end
        drive(k, 1'b0);
        tick(cpb);
        for (int i = 0; i < 8; i++) begin
            drive(k, d[i]);
            tick(cpb);
        end
        if (pm != 0) begin
            drive(k, par);
            tick(cpb);
        end
        for (int i = 0; i < sb; i++) begin
            drive(k, stops[i]);
            if (i == sb - 1) stop_cyc = cyc;
            tick(cpb);
        end
        drive(k, 1'b1);
        tick(2 + int'($urandom_range(0, 3)));
    endtask

    task automatic monitor_step(input int k);
        logic       v, r;
        logic [7:0] d;
        logic [2:0] f;
        exp_t       e;
        int         lat;
        v = (k == 0) ? if0.rx_valid : if1.rx_valid;
        r = (k == 0) ? rdy0 : rdy1;
        d = (k == 0) ? if0.rx_data : if1.rx_data;
        f = (k == 0) ? {if0.parity_err, if0.frame_err, if0.break_det}
                     : {if1.parity_err, if1.frame_err, if1.break_det};
        if (k == 0 && lat_en && v && !pv0) begin
            lat = cyc - (stop_cyc + 1 + CPB0 / 2);
            checks++;
            if (lat < 2 || lat > 3) begin
                errors++;
                $display("FAIL valid_latency: got %0d cycles after stop centre, expected 2..3", lat);
            end
        end
        if (v && r) begin
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL dut%0d_unexpected: got data 0x%0h flags %b, expected no output", k, d, f);
            end else begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                check((k == 0) ? "dut0_frame{data,perr,ferr,brk}" : "dut1_frame{data,perr,ferr,brk}",
                      32'({d, f}), 32'(e));
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            monitor_step(0);
            monitor_step(1);
        end
        pv0 <= if0.rx_valid;
    end

    initial begin
        logic [7:0] d;
        logic       par;
        logic [1:0] st;
        bit         seen;

        rst_n = 1'b0;
        tick(3);
        check("rst_valid0", 32'(if0.rx_valid), 0);
        check("rst_data0", 32'(if0.rx_data), 0);
        check("rst_flags0", 32'({if0.parity_err, if0.frame_err, if0.break_det}), 0);
        check("rst_ovr_busy0", 32'({ovr0, busy0}), 0);
        check("rst_valid1", 32'(if1.rx_valid), 0);
        rst_n = 1'b1;
        tick(3);

        // 8N1 byte with consumer always ready; valid must be a single-cycle pulse.
        lat_en = 1'b1;
        send_frame(0, 8'h3F, 1'b0, 2'b11, 1'b1);
        lat_en = 1'b0;
        check("s1_valid_pulse", 32'(if0.rx_valid), 0);

        // Even parity: deliberately wrong bit, then the correct one.
        send_frame(1, 8'hA5, 1'b1, 2'b11, 1'b1);
        send_frame(1, 8'hA5, 1'b0, 2'b11, 1'b1);

        // Low stop bit, then a clean frame.
        send_frame(0, 8'h55, 1'b0, 2'b10, 1'b1);
        send_frame(0, 8'h12, 1'b0, 2'b11, 1'b1);

        // Stalled consumer: second frame overruns and is dropped.
        rdy0 = 1'b0;
        send_frame(0, 8'h11, 1'b0, 2'b11, 1'b1);
        send_frame(0, 8'h22, 1'b0, 2'b11, 1'b0);
        check("s4_held_data", 32'(if0.rx_data), 32'h11);
        check("s4_held_valid", 32'(if0.rx_valid), 1);
        check("s4_overrun", 32'(ovr0), 1);
        rdy0 = 1'b1;
        tick(1);
        rdy0 = 1'b0;
        check("s4_consumed_valid", 32'(if0.rx_valid), 0);
        check("s4_consumed_overrun", 32'(ovr0), 0);
        check("s4_data_kept", 32'(if0.rx_data), 32'h11);
        rdy0 = 1'b1;
        send_frame(0, 8'h33, 1'b0, 2'b11, 1'b1);

        // Short glitch must be rejected as a false start.
        ser0 = 1'b0;
        tick(2);
        ser0 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (busy0) seen = 1'b1;
            tick(1);
        end
        check("s5_glitch_busy_seen", 32'(seen), 1);
        check("s5_glitch_idle", 32'(busy0), 0);
        send_frame(0, 8'hC3, 1'b0, 2'b11, 1'b1);

        // Asynchronous reset mid-frame.
        ser0 = 1'b0;
        tick(3 * CPB0);
        rst_n = 1'b0;
        #5;
        check("s5_rst_data", 32'(if0.rx_data), 0);
        check("s5_rst_valid_flags", 32'({if0.rx_valid, if0.parity_err, if0.frame_err, if0.break_det}), 0);
        check("s5_rst_ovr_busy", 32'({ovr0, busy0}), 0);
        ser0 = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        check("s5_post_rst_idle", 32'({busy0, if0.rx_valid}), 0);

        // Line held low for 15 bit periods: exactly one break commit.
        q0.push_back(model(0, 8'h00, 1'b0, 2'b00));
        ser0 = 1'b0;
        tick(15 * CPB0);
        check("s6_single_break_commit", 32'(q0.size()), 0);
        check("s6_busy_while_low", 32'(busy0), 1);
        ser0 = 1'b1;
        tick(4);
        send_frame(0, 8'h7E, 1'b0, 2'b11, 1'b1);

        // Random frames on both instances.
        for (int n = 0; n < 32; n++) begin
            int k;
            k     = n % 2;
            d     = 8'($urandom);
            par   = good_par(k, d) ^ ($urandom_range(0, 3) == 0);
            st[0] = ($urandom_range(0, 4) != 0);
            st[1] = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 15) == 0) d = 8'h00;
            send_frame(k, d, par, st, 1'b1);
        end

        for (int i = 0; i < 200 && (q0.size() != 0 || q1.size() != 0); i++) tick(1);
        check("drain_q0", 32'(q0.size()), 0);
        check("drain_q1", 32'(q1.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #(100 * 60000);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
